// File: rtl/booth_arbiter_if.sv
`default_nettype none
// ============================================================================
// Module : booth_arbiter_if
// Requester handshake plus multiplier-side signals of the Booth arbiter.
// Rev    : 1.0
// ============================================================================
interface booth_arbiter_if #(
    parameter int N = 3
);
    logic             req0;
    logic             req1;
    logic [N-1:0]     m0;
    logic [N-1:0]     q0;
    logic [N-1:0]     m1;
    logic [N-1:0]     q1;
    logic             ack0;
    logic             ack1;
    logic             done0;
    logic             done1;
    logic [2*N-1:0]   res;
    logic             err;
    logic             busy;
    logic             mul_start;
    logic [N-1:0]     mul_m;
    logic [N-1:0]     mul_q;
    logic             mul_fin;
    logic [2*N-1:0]   mul_res;

    modport slave (
        input  req0, req1, m0, q0, m1, q1, mul_fin, mul_res,
        output ack0, ack1, done0, done1, res, err, busy, mul_start, mul_m, mul_q
    );

    modport master (
        output req0, req1, m0, q0, m1, q1, mul_fin, mul_res,
        input  ack0, ack1, done0, done1, res, err, busy, mul_start, mul_m, mul_q
    );
endinterface
`default_nettype wire

// File: rtl/booth_arbiter.sv
`default_nettype none
// ============================================================================
// Module : booth_arbiter
// Round-robin sharing of one sequential Booth multiplier between two requesters.
// Rev    : 1.0
// ============================================================================
module booth_arbiter #(
    parameter int N       = 3,
    parameter int TIMEOUT = 16
) (
    input  wire logic       clk,
    input  wire logic       reset,
    booth_arbiter_if.slave  bus
);
    localparam int                c_WD_W    = (TIMEOUT > 2) ? $clog2(TIMEOUT) : 1;
    localparam logic [c_WD_W-1:0] c_WD_LAST = c_WD_W'(TIMEOUT - 1);

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_LOAD = 2'd1,
        S_RUN  = 2'd2,
        S_DONE = 2'd3
    } state_t;

    state_t              r_state;
    logic                r_last;
    logic                r_owner;
    logic [c_WD_W-1:0]   r_wd;
    logic                r_ack0;
    logic                r_ack1;
    logic                r_done0;
    logic                r_done1;
    logic [2*N-1:0]      r_res;
    logic                r_err;
    logic                r_busy;
    logic                r_start;
    logic [N-1:0]        r_m;
    logic [N-1:0]        r_q;

    logic                w_any;
    logic                w_gnt;

    // On a tie the requester not served last wins.
    assign w_any = bus.req0 | bus.req1;
    assign w_gnt = (bus.req0 & bus.req1) ? ~r_last : bus.req1;

    always_ff @(posedge clk) begin
        if (reset) begin
            r_state <= S_IDLE;
            r_last  <= 1'b1;
            r_owner <= 1'b0;
            r_wd    <= '0;
            r_ack0  <= 1'b0;
            r_ack1  <= 1'b0;
            r_done0 <= 1'b0;
            r_done1 <= 1'b0;
            r_res   <= '0;
            r_err   <= 1'b0;
            r_busy  <= 1'b0;
            r_start <= 1'b0;
            r_m     <= '0;
            r_q     <= '0;
        end else begin
            r_ack0  <= 1'b0;
            r_ack1  <= 1'b0;
            r_done0 <= 1'b0;
            r_done1 <= 1'b0;
            r_start <= 1'b0;
            case (r_state)
                S_IDLE: begin
                    if (w_any) begin
                        r_owner <= w_gnt;
                        r_m     <= w_gnt ? bus.m1 : bus.m0;
                        r_q     <= w_gnt ? bus.q1 : bus.q0;
                        r_ack0  <= ~w_gnt;
                        r_ack1  <= w_gnt;
                        r_start <= 1'b1;
                        r_busy  <= 1'b1;
                        r_state <= S_LOAD;
                    end
                end
                S_LOAD: begin
                    r_wd    <= '0;
                    r_state <= S_RUN;
                end
                S_RUN: begin
                    r_wd <= r_wd + 1'b1;
                    // A zero watchdog marks the first RUN cycle, where fin may be stale.
                    if ((r_wd != '0) && bus.mul_fin) begin
                        r_res   <= bus.mul_res;
                        r_err   <= 1'b0;
                        r_state <= S_DONE;
                    end else if (r_wd == c_WD_LAST) begin
                        r_res   <= '0;
                        r_err   <= 1'b1;
                        r_state <= S_DONE;
                    end
                end
                S_DONE: begin
                    r_done0 <= ~r_owner;
                    r_done1 <= r_owner;
                    r_last  <= r_owner;
                    r_busy  <= 1'b0;
                    r_state <= S_IDLE;
                end
                default: r_state <= S_IDLE;
            endcase
        end
    end

    assign bus.ack0      = r_ack0;
    assign bus.ack1      = r_ack1;
    assign bus.done0     = r_done0;
    assign bus.done1     = r_done1;
    assign bus.res       = r_res;
    assign bus.err       = r_err;
    assign bus.busy      = r_busy;
    assign bus.mul_start = r_start;
    assign bus.mul_m     = r_m;
    assign bus.mul_q     = r_q;
endmodule
`default_nettype wire

// File: tb/tb_booth_arbiter.sv
`default_nettype none
// ============================================================================
// Module : tb_booth_arbiter
// Self-checking bench for booth_arbiter with a behavioural N=3 multiplier.
// Rev    : 1.0
// ============================================================================
module tb_booth_arbiter;
    localparam int N = 3;
    localparam int TO = 16;

    logic clk = 1'b0;
    logic reset;
    int   tests = 0;
    int   fails = 0;
    int   cyc = 0;
    int   mode = 0;          // 0 model, 1 fin tied low, 2 scripted
    logic s_fin = 1'b0;
    logic [5:0] s_res = '0;
    int   mcnt = 0;
    int   overlap = 0;
    int   done_cnt0 = 0;
    int   done_cnt1 = 0;
    int   ack_id[$];
    int   ack_cyc[$];
    logic [6:0] exp_q[2][$];
    logic [5:0] w_sm, w_sq, w_prod;

    booth_arbiter_if #(.N(N)) bus();

    booth_arbiter #(.N(N), .TIMEOUT(TO)) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    // Behavioural multiplier: fin rises in the (N+1)th cycle after the start pulse and holds.
    always @(posedge clk) begin
        if (reset)                         mcnt <= 0;
        else if (bus.mul_start)            mcnt <= 1;
        else if (mcnt != 0 && mcnt < N+1)  mcnt <= mcnt + 1;
    end
    assign w_sm   = {{3{bus.mul_m[2]}}, bus.mul_m};
    assign w_sq   = {{3{bus.mul_q[2]}}, bus.mul_q};
    assign w_prod = w_sm * w_sq;
    assign bus.mul_fin = (mode == 1) ? 1'b0 : (mode == 2) ? s_fin : (mcnt == N+1);
    assign bus.mul_res = (mode == 2) ? s_res : w_prod;

    always @(negedge clk) begin
        if (bus.ack0) begin ack_id.push_back(0); ack_cyc.push_back(cyc); end
        if (bus.ack1) begin ack_id.push_back(1); ack_cyc.push_back(cyc); end
        if ((bus.ack0 | bus.ack1) && (bus.done0 | bus.done1)) overlap++;
        if (bus.done0) done_cnt0++;
        if (bus.done1) done_cnt1++;
    end

    task automatic apply_reset;
        reset = 1'b1;
        bus.req0 = 1'b0;
        bus.req1 = 1'b0;
        repeat (2) @(negedge clk);
        reset = 1'b0;
        @(negedge clk);
    endtask

    // One operation of requester id; call at a negedge. Expected result is queued first.
    task automatic do_op(input int id, input logic [2:0] m, input logic [2:0] q,
                         input logic [5:0] exp_res, input logic exp_err,
                         input int exp_lat, input int exp_ack_wait);
        int n;
        int t_ack;
        logic [6:0] e;
        exp_q[id].push_back({exp_err, exp_res});
        if (id == 0) begin bus.m0 = m; bus.q0 = q; bus.req0 = 1'b1; end
        else         begin bus.m1 = m; bus.q1 = q; bus.req1 = 1'b1; end
        n = 0;
        while (!((id == 0) ? bus.ack0 : bus.ack1) && n < 200) begin
            @(negedge clk);
            n++;
        end
        if (id == 0) bus.req0 = 1'b0; else bus.req1 = 1'b0;
        tests++;
        if (n >= 200) begin
            fails++;
            $display("FAIL ack_timeout req%0d: no ack after %0d cycles, required one", id, n);
            void'(exp_q[id].pop_back());
            return;
        end
        if (exp_ack_wait >= 0) begin
            tests++;
            if (n !== exp_ack_wait) begin
                fails++;
                $display("FAIL ack_latency req%0d: got %0d cycles, required %0d", id, n, exp_ack_wait);
            end
        end
        t_ack = cyc;
        n = 0;
        while (!((id == 0) ? bus.done0 : bus.done1) && n < 100) begin
            @(negedge clk);
            n++;
        end
        e = exp_q[id].pop_front();
        tests++;
        if (n >= 100) begin
            fails++;
            $display("FAIL done_timeout req%0d: no done after %0d cycles, required one", id, n);
            return;
        end
        tests++;
        if ({bus.err, bus.res} !== e) begin
            fails++;
            $display("FAIL result req%0d: got err=%0b res=%b, required err=%0b res=%b",
                     id, bus.err, bus.res, e[6], e[5:0]);
        end
        tests++;
        if ((cyc - t_ack) !== exp_lat) begin
            fails++;
            $display("FAIL done_latency req%0d: got %0d, required %0d", id, cyc - t_ack, exp_lat);
        end
    endtask

    task automatic test_reset;
        reset = 1'b1;
        bus.req0 = 1'b0; bus.req1 = 1'b0;
        bus.m0 = '0; bus.q0 = '0; bus.m1 = '0; bus.q1 = '0;
        repeat (3) @(negedge clk);
        tests++;
        if ({bus.ack0, bus.ack1, bus.done0, bus.done1, bus.busy, bus.mul_start} !== 6'b0) begin
            fails++;
            $display("FAIL reset_ctrl: got %b, required 000000",
                     {bus.ack0, bus.ack1, bus.done0, bus.done1, bus.busy, bus.mul_start});
        end
        tests++;
        if ({bus.err, bus.res} !== 7'b0) begin
            fails++;
            $display("FAIL reset_result: got err=%0b res=%b, required 0/0", bus.err, bus.res);
        end
        tests++;
        if ({bus.mul_m, bus.mul_q} !== 6'b0) begin
            fails++;
            $display("FAIL reset_operands: got %b, required 000000", {bus.mul_m, bus.mul_q});
        end
        reset = 1'b0;
        repeat (3) @(negedge clk);
        tests++;
        if ({bus.busy, bus.ack0, bus.ack1} !== 3'b0) begin
            fails++;
            $display("FAIL idle_no_req: got busy/ack=%b, required 000", {bus.busy, bus.ack0, bus.ack1});
        end
    endtask

    task automatic test_single;
        int d1;
        d1 = done_cnt1;
        do_op(0, 3'd3, 3'b110, 6'b111010, 1'b0, 6, 1);
        repeat (2) @(negedge clk);
        tests++;
        if (done_cnt1 !== d1) begin
            fails++;
            $display("FAIL single_no_done1: got %0d done1 pulses, required 0", done_cnt1 - d1);
        end
    endtask

    task automatic test_simultaneous;
        int base;
        apply_reset();
        base = ack_id.size();
        fork
            do_op(0, 3'd2, 3'd3, 6'd6, 1'b0, 6, 1);
            do_op(1, 3'b100, 3'b100, 6'd16, 1'b0, 6, -1);
        join
        @(negedge clk);
        tests++;
        if (ack_id.size() < base + 2) begin
            fails++;
            $display("FAIL sim_ack_count: got %0d acks, required 2", ack_id.size() - base);
        end else begin
            tests++;
            if ({ack_id[base][0], ack_id[base+1][0]} !== 2'b01) begin
                fails++;
                $display("FAIL sim_order: got %0d,%0d, required 0,1", ack_id[base], ack_id[base+1]);
            end
            tests++;
            if ((ack_cyc[base+1] - ack_cyc[base]) !== 7) begin
                fails++;
                $display("FAIL sim_interval: got %0d, required 7", ack_cyc[base+1] - ack_cyc[base]);
            end
        end
    endtask

    task automatic test_saturation;
        int base;
        logic [2:0] m0s[3], q0s[3], m1s[3], q1s[3];
        logic [5:0] e0s[3], e1s[3];
        m0s = '{3'd1, 3'd2, 3'd3};       q0s = '{3'd3, 3'b101, 3'd2};
        e0s = '{6'd3, 6'b111010, 6'd6};
        m1s = '{3'b111, 3'b110, 3'd3};   q1s = '{3'b111, 3'd3, 3'b100};
        e1s = '{6'd1, 6'b111010, 6'b110100};
        base = ack_id.size();
        fork
            begin
                for (int k = 0; k < 3; k++) do_op(0, m0s[k], q0s[k], e0s[k], 1'b0, 6, -1);
            end
            begin
                for (int k = 0; k < 3; k++) do_op(1, m1s[k], q1s[k], e1s[k], 1'b0, 6, -1);
            end
        join
        @(negedge clk);
        for (int k = 0; k < 6; k++) begin
            tests++;
            if (base + k >= ack_id.size()) begin
                fails++;
                $display("FAIL sat_grant%0d: missing grant, required req%0d", k, k % 2);
            end else if (ack_id[base+k] !== (k % 2)) begin
                fails++;
                $display("FAIL sat_grant%0d: got req%0d, required req%0d", k, ack_id[base+k], k % 2);
            end
        end
    endtask

    task automatic test_timeout;
        mode = 1;
        do_op(0, 3'd1, 3'd2, 6'd0, 1'b1, TO + 2, 1);
        mode = 0;
        do_op(1, 3'd2, 3'd2, 6'd4, 1'b0, 6, 1);
    endtask

    task automatic test_stale_fin;
        int n;
        int t_ack;
        logic [6:0] e;
        mode = 2;
        s_fin = 1'b1;
        s_res = 6'h2A;
        exp_q[0].push_back({1'b0, 6'd6});
        bus.m0 = 3'd2; bus.q0 = 3'd3; bus.req0 = 1'b1;
        n = 0;
        while (!bus.ack0 && n < 20) begin @(negedge clk); n++; end
        bus.req0 = 1'b0;
        t_ack = cyc;
        @(negedge clk);
        @(negedge clk); s_fin = 1'b0;
        @(negedge clk);
        @(negedge clk); s_fin = 1'b1; s_res = 6'd6;
        n = 0;
        while (!bus.done0 && n < 40) begin @(negedge clk); n++; end
        e = exp_q[0].pop_front();
        tests++;
        if (!bus.done0) begin
            fails++;
            $display("FAIL stale_done: no done0 seen, required one");
        end else begin
            tests++;
            if ({bus.err, bus.res} !== e) begin
                fails++;
                $display("FAIL stale_result: got err=%0b res=%b, required err=%0b res=%b",
                         bus.err, bus.res, e[6], e[5:0]);
            end
            tests++;
            if ((cyc - t_ack) !== 6) begin
                fails++;
                $display("FAIL stale_latency: got %0d, required 6", cyc - t_ack);
            end
        end
        mode = 0;
    endtask

    task automatic test_reset_in_run;
        int n;
        int d0;
        bus.m0 = 3'd3; bus.q0 = 3'd3; bus.req0 = 1'b1;
        n = 0;
        while (!bus.ack0 && n < 20) begin @(negedge clk); n++; end
        bus.req0 = 1'b0;
        d0 = done_cnt0;
        repeat (3) @(negedge clk);
        reset = 1'b1;
        @(negedge clk);
        tests++;
        if ({bus.busy, bus.done0, bus.done1, bus.mul_start} !== 4'b0) begin
            fails++;
            $display("FAIL rst_run_ctrl: got busy/done0/done1/start=%b, required 0000",
                     {bus.busy, bus.done0, bus.done1, bus.mul_start});
        end
        tests++;
        if ({bus.err, bus.res} !== 7'b0) begin
            fails++;
            $display("FAIL rst_run_result: got err=%0b res=%b, required 0/0", bus.err, bus.res);
        end
        reset = 1'b0;
        repeat (8) @(negedge clk);
        tests++;
        if (done_cnt0 !== d0 || bus.busy !== 1'b0) begin
            fails++;
            $display("FAIL rst_run_nodone: got %0d done0 pulses busy=%0b, required 0/0",
                     done_cnt0 - d0, bus.busy);
        end
        do_op(0, 3'b111, 3'b101, 6'd3, 1'b0, 6, 1);
    endtask

    task automatic test_no_overlap;
        @(negedge clk);
        tests++;
        if (overlap !== 0) begin
            fails++;
            $display("FAIL ack_done_overlap: got %0d cycles, required 0", overlap);
        end
    endtask

    initial begin
        #500000;
        $display("FAIL global_timeout: simulation exceeded its time budget");
        $fatal(1, "time budget exceeded");
    end

    initial begin
        reset = 1'b1;
        bus.req0 = 1'b0; bus.req1 = 1'b0;
        bus.m0 = '0; bus.q0 = '0; bus.m1 = '0; bus.q1 = '0;
        @(negedge clk);
        test_reset();
        test_single();
        test_simultaneous();
        test_saturation();
        test_timeout();
        test_stale_fin();
        test_reset_in_run();
        test_no_overlap();
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end
endmodule
`default_nettype wire

// File: doc/booth_arbiter.md
# booth_arbiter

Round-robin scheduler that shares one sequential Booth multiplier (`multiplicador`, N-bit operands, 2N-bit result, `fin` completion flag) between two requesters. It accepts operand pairs through a req/ack handshake and latches them. It launches the multiplier by pulsing its active-high load/reset input, waits for `fin` under a watchdog, and returns the 2N-bit product to the owning requester with a one-cycle done pulse. It sits between the client logic and the multiplier instance; the multiplier itself is unchanged.

## Interface
- N, 3, operand width in bits; product is 2N bits, two's complement
- TIMEOUT, 16, maximum cycles spent in RUN before the operation is aborted; must be at least 2N+2
- clk  in  1  clock; all state changes on its rising edge
- reset  in  1  synchronous, active-high reset
- req0 / req1  in  1  requester i has a valid operand pair; held high until acki
- m0, q0 / m1, q1  in  N each  multiplicand / multiplier of requester i; stable while reqi=1
- ack0 / ack1  out  1  one-cycle pulse: operands of requester i latched this edge
- done0 / done1  out  1  one-cycle pulse: result for requester i valid on res/err
- res  out  2N  product of the last completed operation; held until the next DONE
- err  out  1  1 = last operation timed out (res forced to 0); held with res
- busy  out  1  high in LOAD, RUN and DONE
- mul_start  out  1  to multiplier reset/load input, one-cycle pulse
- mul_m, mul_q  out  N each  latched operands to the multiplier, stable from LOAD through DONE
- mul_fin  in  1  multiplier completion flag
- mul_res  in  2N  multiplier product, valid while mul_fin=1

## Operation
- State machine: IDLE -> LOAD -> RUN -> DONE -> IDLE.
- IDLE: if any reqi, grant one requester.
  - Only one requesting: grant it.
  - Both requesting: grant the one not served last (`last` register; reset value 1, so requester 0 wins the first tie).
  - On grant: latch mi/qi into mul_m/mul_q, set owner=i, pulse acki, go to LOAD.
  - No request: stay in IDLE.
- LOAD: mul_start=1 for exactly this cycle; clear watchdog counter; go to RUN.
- RUN: increment watchdog each cycle. mul_fin is ignored in the first RUN cycle, because a stale fin from the previous operation may still be visible.
  - From the second RUN cycle: if mul_fin=1, capture mul_res into res, err=0, go to DONE.
  - Else if watchdog reaches TIMEOUT-1: res=0, err=1, go to DONE.
  - If fin and timeout occur in the same cycle, fin wins.
- DONE: pulse done_owner; last<=owner; go to IDLE.
- Requests are sampled only in IDLE. A requester that raises req during an operation is served at the next IDLE. The loser of a tie is guaranteed service on the next grant.
- Requests from the same requester are not reordered. A requester must not re-raise req before its done pulse; behaviour otherwise is undefined.
- res/err are overwritten only in the RUN->DONE transition.
- Width rule: res is exactly the 2N-bit mul_res, with no sign extension or truncation in this block.

## Timing
- Reset values:
  - state=IDLE, last=1, owner=0, watchdog=0
  - ack0=ack1=done0=done1=0, mul_start=0, busy=0
  - res=0, err=0, mul_m=mul_q=0
- Reset mid-operation aborts it with no done pulse. mul_start is not asserted by the arbiter during reset; the multiplier receives the system reset separately.
- ack is asserted in the cycle after req is seen in IDLE: registered, one pulse per operation.
- Latency from the ack cycle to the done cycle: 1 (LOAD) + K (RUN, where K = cycle in which fin is first accepted, K ≥ 2) + 1. With the N=3 multiplier, K = N+1, so ack-to-done is 6 cycles. Timeout case: ack-to-done is TIMEOUT+2 cycles.
- Back-to-back operation: the next grant can occur in the cycle after DONE, giving a minimum initiation interval of K+3 cycles.
- done and ack are never both high in the same cycle.

## Test plan
- Single request: req0, m0=3, q0=-2 (3'b110) -> ack0 one cycle later; done0 with res=6'b111010 (-6), err=0; done1 never asserted.
- Simultaneous requests after reset: req0 (2×3) and req1 (-4×-4), both held high -> requester 0 served first (res=6) and requester 1 next (res=16). Order of acks: ack0, then ack1, with no IDLE gap longer than 1 cycle.
- Fairness under saturation: both reqi held high continuously for 6 operations -> grants alternate 0,1,0,1,0,1.
- Timeout: mul_fin tied low, TIMEOUT=16 -> done pulse TIMEOUT+2 cycles after ack, res=0, err=1. A subsequent good operation then clears err.
- Stale fin: mul_fin held high through LOAD and the first RUN cycle, then low for 2 cycles, then high -> result captured only at the later fin.
- Reset in RUN: assert reset during the third RUN cycle -> next cycle has state IDLE, busy=0, and no done pulse. A new request afterwards completes normally.
